work_tx: RTL and testbench

Serial transmitter for a 64-byte work packet (midstate + data2), the transmit-side counterpart of the work receiver in the serial core. It runs in the comm clock domain and drives a UART line toward a downstream miner or a loopback test host. A single start pulse latches a 512-bit job and sends it as 64 framed 8N1 bytes. A one-cycle done pulse marks the end of the packet.

---
 rtl/work_tx.sv | 118 +++++++++++
 tb/tb_work_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/work_tx.sv
// work_tx: sends a latched 512-bit work packet (midstate then data2) as
// 64 UART 8N1 frames, most-significant byte first, LSB first within a byte.
//
// Handshake: start is a request sampled every rising edge; it is accepted
// only on an edge where busy is low. The accepting edge loads the payload
// and raises busy. Requests while busy is high are dropped without effect.
// busy falls on the same edge that done pulses for one cycle, and a request
// seen in the done cycle is accepted on the following edge.
module work_tx #(
   parameter int CLOCK = 25000000,
   parameter int BAUD  = 115200
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [255:0] midstate,
   input  logic [255:0] data2,
   output logic         tx,
   output logic         busy,
   output logic         done,
   output logic [5:0]   byte_idx
);

   localparam int DIV = CLOCK / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t         state;
   logic [511:0]   payload;
   logic [CW-1:0]  cnt;
   logic [2:0]     bit_cnt;
   logic [7:0]     cur_byte;
   logic           bit_end;

   // The byte on the line is always the top of the payload; it shifts up
   // by one byte after each stop bit.
   assign cur_byte = payload[511:504];
   assign bit_end  = (cnt == LAST);

   // Frame sequencer: every output is registered so tx only moves on a bit
   // boundary, and reset forces the line high asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         payload  <= '0;
         cnt      <= '0;
         bit_cnt  <= '0;
         byte_idx <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               tx       <= 1'b1;
               busy     <= 1'b0;
               byte_idx <= '0;
               cnt      <= '0;
               bit_cnt  <= '0;
               if (start) begin
                  payload <= {midstate, data2};
                  tx      <= 1'b0;
                  busy    <= 1'b1;
                  state   <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_cnt <= '0;
                  tx      <= cur_byte[0];
                  state   <= DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= cur_byte[bit_cnt + 3'd1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (byte_idx == 6'd63) begin
                     tx       <= 1'b1;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     byte_idx <= '0;
                     state    <= IDLE;
                  end else begin
                     byte_idx <= byte_idx + 6'd1;
                     payload  <= {payload[503:0], 8'h00};
                     tx       <= 1'b0;
                     state    <= START;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_work_tx.sv
// tb_work_tx: directed bench for work_tx at DIV=4. Stimulus pushes the
// expected byte stream into exp_q on acceptance; a UART monitor decodes tx
// and compares each frame against the queue.
module tb_work_tx;

   localparam logic [255:0] MS_A = 256'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F20;
   localparam logic [255:0] D2_A = 256'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAFB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
   localparam logic [255:0] MS_B = {8'h35, 248'h0};
   localparam logic [255:0] D2_B = 256'h0;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [255:0] midstate;
   logic [255:0] data2;
   logic         tx;
   logic         busy;
   logic         done;
   logic [5:0]   byte_idx;

   logic [7:0]   exp_q[$];
   int           pass_cnt;
   int           total_cnt;

   work_tx #(.CLOCK(400), .BAUD(100)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .midstate (midstate),
      .data2    (data2),
      .tx       (tx),
      .busy     (busy),
      .done     (done),
      .byte_idx (byte_idx)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else
         pass_cnt++;
   endtask

   task automatic push_bytes(input logic [255:0] ms, input logic [255:0] d2);
      logic [511:0] p;
      p = {ms, d2};
      for (int n = 0; n < 64; n++) exp_q.push_back(p[511 - 8*n -: 8]);
   endtask

   // driver: present a job and pulse (or hold) start; returns 1ns after E
   task automatic accept(input logic [255:0] ms, input logic [255:0] d2, input bit hold);
      @(negedge clk);
      midstate = ms;
      data2    = d2;
      start    = 1'b1;
      @(posedge clk);
      #1;
      push_bytes(ms, d2);
      check("accept_tx", 64'(tx), 64'd0);
      check("accept_busy", 64'(busy), 64'd1);
      if (!hold) start = 1'b0;
   endtask

   // follows a packet from E to its done edge; optionally pokes an ignored start
   task automatic wait_done(input bit inject);
      int c;
      int bad_busy;
      int bad_idx;
      bit seen;
      c = 0; bad_busy = 0; bad_idx = 0; seen = 0;
      while (!seen && c < 3000) begin
         if (byte_idx !== 6'(c / 40)) bad_idx++;
         if (busy !== 1'b1) bad_busy++;
         if (inject && c == 100) begin
            start    = 1'b1;
            midstate = ~midstate;
            data2    = ~data2;
         end
         if (inject && c == 101) start = 1'b0;
         @(posedge clk);
         #1;
         c++;
         if (done === 1'b1) seen = 1;
      end
      check("done_time", 64'(c), 64'd2560);
      check("busy_held", 64'(bad_busy), 64'd0);
      check("byte_idx_track", 64'(bad_idx), 64'd0);
      check("done_busy_low", 64'(busy), 64'd0);
      check("done_tx_high", 64'(tx), 64'd1);
      check("done_idx_zero", 64'(byte_idx), 64'd0);
   endtask

   // scoreboard monitor: decode 8N1 frames sampled near each bit's start+1
   initial begin
      logic [9:0] bits;
      bit ok;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx === 1'b0) begin
            ok = 1;
            for (int j = 0; j < 10; j++) begin
               repeat ((j == 0) ? 1 : 4) @(negedge clk);
               if (rst_n !== 1'b1) begin
                  ok = 0;
                  break;
               end
               bits[j] = tx;
            end
            if (ok) begin
               check("start_bit", 64'(bits[0]), 64'd0);
               check("stop_bit", 64'(bits[9]), 64'd1);
               if (exp_q.size() == 0)
                  check("unexpected_byte", 64'(bits[8:1]), 64'hFFFF);
               else
                  check("byte", 64'(bits[8:1]), 64'(exp_q.pop_front()));
               repeat (2) @(negedge clk);
            end
         end
      end
   end

   // main stimulus
   initial begin
      int bad_tx;
      int bad_busy;
      int bad_done;
      int bad_idx;
      int extra_done;
      pass_cnt = 0; total_cnt = 0;
      rst_n = 1'b0; start = 1'b0; midstate = '0; data2 = '0;

      // reset idle
      repeat (3) @(posedge clk);
      #1;
      check("reset_tx", 64'(tx), 64'd1);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_idx", 64'(byte_idx), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad_tx = 0; bad_busy = 0; bad_done = 0; bad_idx = 0;
      repeat (50) begin
         @(posedge clk);
         #1;
         if (tx !== 1'b1) bad_tx++;
         if (busy !== 1'b0) bad_busy++;
         if (done !== 1'b0) bad_done++;
         if (byte_idx !== 6'd0) bad_idx++;
      end
      check("idle_tx", 64'(bad_tx), 64'd0);
      check("idle_busy", 64'(bad_busy), 64'd0);
      check("idle_done", 64'(bad_done), 64'd0);
      check("idle_idx", 64'(bad_idx), 64'd0);

      // single packet
      accept(MS_A, D2_A, 0);
      wait_done(0);
      @(posedge clk);
      #1;
      check("done_pulse", 64'(done), 64'd0);

      // bit order: first frame must decode to 0x35
      repeat (5) @(posedge clk);
      accept(MS_B, D2_B, 0);
      wait_done(0);

      // ignored start mid-packet, done only once
      repeat (3) @(posedge clk);
      accept(MS_A, D2_A, 0);
      wait_done(1);
      extra_done = 0;
      repeat (60) begin
         @(posedge clk);
         #1;
         if (done !== 1'b0) extra_done++;
      end
      check("done_once", 64'(extra_done), 64'd0);

      // back-to-back with start held high
      accept(MS_A, D2_A, 1);
      midstate = MS_B;
      data2    = D2_B;
      wait_done(0);
      check("gap_tx", 64'(tx), 64'd1);
      @(posedge clk);
      #1;
      check("b2b_tx", 64'(tx), 64'd0);
      check("b2b_busy", 64'(busy), 64'd1);
      push_bytes(MS_B, D2_B);
      start = 1'b0;
      wait_done(0);

      // mid-packet reset during byte 5, data bit 3
      repeat (4) @(posedge clk);
      accept(MS_A, D2_A, 0);
      repeat (216) @(posedge clk);
      #1;
      check("pre_reset_idx", 64'(byte_idx), 64'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_tx", 64'(tx), 64'd1);
      check("async_busy", 64'(busy), 64'd0);
      check("async_idx", 64'(byte_idx), 64'd0);
      check("async_done", 64'(done), 64'd0);
      exp_q.delete();
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      accept(MS_A, D2_A, 0);
      wait_done(0);

      repeat (10) @(posedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
